// File: rtl/inst_decode_pipe_if.sv
// Fetch-side and execute-side handshake bundle for the instruction-decode stage.
// The decode stage is the slave; the fetch/execute environment is the master.
interface inst_decode_pipe_if #(
  parameter int INST_W   = 32,
  parameter int OPCODE_W = 2,
  parameter int REG_W    = 5,
  parameter int FUNC_W   = 4,
  parameter int OFFSET_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [INST_W-1:0]   inst;
  logic                out_valid;
  logic                out_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    shamt;
  logic [FUNC_W-1:0]   func;
  logic [OFFSET_W-1:0] offset;
  logic                mem_read;
  logic                mem_write;

  modport master (
    output in_valid, inst, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, shamt, func, offset, mem_read, mem_write
  );

  modport slave (
    input  in_valid, inst, out_ready,
    output in_ready, out_valid, opcode, rs, rt, shamt, func, offset, mem_read, mem_write
  );
endinterface

// File: rtl/inst_decode_pipe.sv
// KGP-RISC decode stage: splits instruction words into fields and buffers them in a DEPTH-entry FIFO.
// Optional macro DECODE_ILLEGAL_EN adds per-record illegal flag and a popped-illegal counter.
module inst_decode_pipe #(
  parameter int                  INST_W    = 32,
  parameter int                  OPCODE_W  = 2,
  parameter int                  REG_W     = 5,
  parameter int                  FUNC_W    = 4,
  parameter int                  OFFSET_W  = 16,
  parameter int                  DEPTH     = 2,
  parameter logic [OPCODE_W-1:0] LOAD_OPC  = 2'b10,
  parameter logic [OPCODE_W-1:0] STORE_OPC = 2'b11,
  parameter int                  CNT_W     = 16
`ifdef DECODE_ILLEGAL_EN
  , parameter logic [FUNC_W-1:0] ALU_FUNC_MAX = 4'd9
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  inst_decode_pipe_if.slave  bus,
  output logic [CNT_W-1:0]   stall_cnt
`ifdef DECODE_ILLEGAL_EN
  , output logic             illegal
  , output logic [CNT_W-1:0] illegal_cnt
`endif
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RS_HI  = INST_W - OPCODE_W - 1;
  localparam int RT_HI  = RS_HI - REG_W;
  localparam int SH_HI  = RT_HI - REG_W;
  localparam int FN_HI  = SH_HI - REG_W;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    shamt;
    logic [FUNC_W-1:0]   func;
    logic [OFFSET_W-1:0] offset;
    logic                mem_read;
    logic                mem_write;
`ifdef DECODE_ILLEGAL_EN
    logic                illegal;
`endif
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  rec_t             dec;
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             push, pop;

  // Decode is purely combinational off the incoming word; offset deliberately overlaps shamt/func.
  always_comb begin
    dec           = '0;
    dec.opcode    = bus.inst[INST_W-1 -: OPCODE_W];
    dec.rs        = bus.inst[RS_HI -: REG_W];
    dec.rt        = bus.inst[RT_HI -: REG_W];
    dec.shamt     = bus.inst[SH_HI -: REG_W];
    dec.func      = bus.inst[FN_HI -: FUNC_W];
    dec.offset    = bus.inst[OFFSET_W-1:0];
    dec.mem_read  = (dec.opcode == LOAD_OPC);
    dec.mem_write = (dec.opcode == STORE_OPC);
`ifdef DECODE_ILLEGAL_EN
    dec.illegal   = (dec.opcode == '0) && (dec.func > ALU_FUNC_MAX);
`endif
  end

  // Ready depends only on the registered count, so a full FIFO never accepts on a popping cycle.
  assign bus.in_ready  = (count_q < DEPTH_C) && rst_n;
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && !bus.in_ready && (stall_q != '1))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign bus.opcode    = head.opcode;
  assign bus.rs        = head.rs;
  assign bus.rt        = head.rt;
  assign bus.shamt     = head.shamt;
  assign bus.func      = head.func;
  assign bus.offset    = head.offset;
  assign bus.mem_read  = head.mem_read;
  assign bus.mem_write = head.mem_write;
  assign stall_cnt     = stall_q;

`ifdef DECODE_ILLEGAL_EN
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  // A pop coinciding with flush is discarded, so it is not counted either.
  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (pop && !flush && head.illegal && (ill_cnt_q != '1))
      ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ill_cnt_q <= '0;
    else        ill_cnt_q <= ill_cnt_d;
  end

  assign illegal     = head.illegal;
  assign illegal_cnt = ill_cnt_q;
`endif
endmodule

// File: tb/tb_inst_decode_pipe.sv
// Directed self-checking bench for inst_decode_pipe; covers the DECODE_ILLEGAL_EN build when defined.
module tb_inst_decode_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] stall_cnt;
`ifdef DECODE_ILLEGAL_EN
  logic        illegal;
  logic [15:0] illegal_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_decode_pipe_if #(.INST_W(32), .OPCODE_W(2), .REG_W(5), .FUNC_W(4), .OFFSET_W(16)) bus ();

  inst_decode_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .stall_cnt   (stall_cnt)
`ifdef DECODE_ILLEGAL_EN
    , .illegal     (illegal)
    , .illegal_cnt (illegal_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec [4];
  logic [1:0]  e_opc [4];
  logic [4:0]  e_rs [4];
  logic        e_mr [4];

  initial begin
    vec[0] = 32'h24C281E5; vec[1] = 32'h44C281E5; vec[2] = 32'h64C281E5; vec[3] = 32'h84C281E5;
    e_opc[0] = 2'd0; e_opc[1] = 2'd1; e_opc[2] = 2'd1; e_opc[3] = 2'd2;
    e_rs[0] = 5'd18; e_rs[1] = 5'd2; e_rs[2] = 5'd18; e_rs[3] = 5'd2;
    e_mr[0] = 1'b0; e_mr[1] = 1'b0; e_mr[2] = 1'b0; e_mr[3] = 1'b1;

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.inst = '0; bus.out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_opcode",    32'(bus.opcode),    32'd0);
    chk("rst_offset",    32'(bus.offset),    32'd0);
    chk("rst_stall",     32'(stall_cnt),     32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: single decode, one-cycle latency
    bus.in_valid = 1'b1; bus.inst = 32'h04C281E5; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_opcode",    32'(bus.opcode),    32'd0);
    chk("t1_rs",        32'(bus.rs),        32'd2);
    chk("t1_rt",        32'(bus.rt),        32'd12);
    chk("t1_shamt",     32'(bus.shamt),     32'd5);
    chk("t1_func",      32'(bus.func),      32'd0);
    chk("t1_offset",    32'(bus.offset),    32'h81E5);
    chk("t1_mem_read",  32'(bus.mem_read),  32'd0);
    chk("t1_mem_write", 32'(bus.mem_write), 32'd0);
    step();
    chk("t1_drained", 32'(bus.out_valid), 32'd0);

    // 2: back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.inst = vec[i];
      step();
      chk("t2_in_ready",  32'(bus.in_ready),  32'd1);
      chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_opcode",    32'(bus.opcode),    32'(e_opc[i]));
      chk("t2_rs",        32'(bus.rs),        32'(e_rs[i]));
      chk("t2_mem_read",  32'(bus.mem_read),  32'(e_mr[i]));
    end
    bus.in_valid = 1'b0;
    step();
    chk("t2_drained", 32'(bus.out_valid), 32'd0);

    // 3: backpressure, stall counting, in-order drain
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.inst = vec[0]; step();
    bus.inst = vec[1]; step();
    chk("t3_full_ready", 32'(bus.in_ready), 32'd0);
    bus.inst = vec[2]; step(); step();
    chk("t3_stall",    32'(stall_cnt),    32'd2);
    chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_head_opc", 32'(bus.opcode),   32'd0);
    chk("t3_head_rs",  32'(bus.rs),       32'd18);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("t3_pop1_opc",   32'(bus.opcode),   32'd1);
    chk("t3_pop1_rs",    32'(bus.rs),       32'd2);
    chk("t3_pop1_ready", 32'(bus.in_ready), 32'd1);
    step();
    chk("t3_drained", 32'(bus.out_valid), 32'd0);
    chk("t3_stall_hold", 32'(stall_cnt), 32'd2);

    // 4: flush while full (blocked push also counts a stall), then flush dropping a push
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.inst = vec[0]; step();
    bus.inst = vec[1]; step();
    bus.inst = vec[3]; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t4_stall",     32'(stall_cnt),     32'd3);
    bus.in_valid = 1'b1; bus.inst = vec[1]; step();
    bus.inst = vec[3]; flush = 1'b1; step();
    flush = 1'b0;
    chk("t4b_out_valid", 32'(bus.out_valid), 32'd0);
    bus.inst = 32'h04C281E5; bus.out_ready = 1'b1; step();
    bus.in_valid = 1'b0;
    chk("t4b_head_opc", 32'(bus.opcode), 32'd0);
    chk("t4b_head_rs",  32'(bus.rs),     32'd2);
    chk("t4b_mem_read", 32'(bus.mem_read), 32'd0);
    step();
    chk("t4b_drained", 32'(bus.out_valid), 32'd0);

    // 5: reset while full with stall_cnt=5
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.inst = vec[0]; step();
    bus.inst = vec[1]; step();
    bus.inst = vec[2]; step(); step();
    chk("t5_stall_pre", 32'(stall_cnt),    32'd5);
    chk("t5_full",      32'(bus.in_ready), 32'd0);
    rst_n = 1'b0; bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_stall",     32'(stall_cnt),     32'd0);
    chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
    chk("t5_rs",        32'(bus.rs),        32'd0);

`ifdef DECODE_ILLEGAL_EN
    // 6: illegal flag and counter, including the func==ALU_FUNC_MAX boundary
    bus.in_valid = 1'b1; bus.inst = 32'h0004F000; step();
    bus.in_valid = 1'b0;
    chk("t6_illegal", 32'(illegal),  32'd1);
    chk("t6_func",    32'(bus.func), 32'hE);
    chk("t6_cnt_pre", 32'(illegal_cnt), 32'd0);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    chk("t6_cnt", 32'(illegal_cnt), 32'd1);
    bus.in_valid = 1'b1; bus.inst = 32'h04C281E5; step();
    bus.in_valid = 1'b0;
    chk("t6_legal", 32'(illegal), 32'd0);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    chk("t6_cnt_keep", 32'(illegal_cnt), 32'd1);
    bus.in_valid = 1'b1; bus.inst = 32'h00004800; step();
    bus.in_valid = 1'b0;
    chk("t6_func9", 32'(illegal), 32'd0);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.inst = 32'h00005000; step();
    bus.in_valid = 1'b0;
    chk("t6_funcA", 32'(illegal), 32'd1);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    chk("t6_cnt2", 32'(illegal_cnt), 32'd2);
    bus.in_valid = 1'b1; bus.inst = 32'h40007000; step();
    bus.in_valid = 1'b0;
    chk("t6_opc1", 32'(illegal), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_decode_pipe.md
Name: inst_decode_pipe

Overview:
- Registered, parametrised instruction-decode stage for the KGP-RISC core.
- Accepts fetched instruction words over a valid/ready handshake and splits them into fields:
  - opcode, rs, rt, shamt, func, offset
  - memory-control flags
- Buffers decoded records in a DEPTH-entry FIFO so fetch and execute can stall independently.
- Sits between instruction fetch and register-read/execute.
- Adds flush support and a stall counter.

Parameters:
INST_W, 32, instruction word width
OPCODE_W, 2, opcode field width, taken from the top bits
REG_W, 5, width of each register/shamt field
FUNC_W, 4, function field width
OFFSET_W, 16, immediate/offset width, taken from the low bits
DEPTH, 2, FIFO entries; power of two, >=2
LOAD_OPC, 2'b10, opcode asserting mem_read
STORE_OPC, 2'b11, opcode asserting mem_write
CNT_W, 16, stall counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  drop all buffered and incoming instructions
in_valid  in  1  inst is valid
in_ready  out  1  stage can accept inst this cycle
inst  in  INST_W  instruction word
out_valid  out  1  decoded record at head is valid
out_ready  in  1  consumer accepts head record
opcode  out  OPCODE_W  inst[INST_W-1 -: OPCODE_W]
rs  out  REG_W  next REG_W bits below opcode
rt  out  REG_W  next REG_W bits below rs
shamt  out  REG_W  next REG_W bits below rt
func  out  FUNC_W  next FUNC_W bits below shamt
offset  out  OFFSET_W  inst[OFFSET_W-1:0]; overlaps shamt/func by design
mem_read  out  1  opcode==LOAD_OPC
mem_write  out  1  opcode==STORE_OPC
stall_cnt  out  CNT_W  cycles with in_valid && !in_ready

Field positions at default parameters:
- opcode[31:30], rs[29:25], rt[24:20], shamt[19:15], func[14:11], offset[15:0].

Behaviour:

Reset (rst_n=0 at a clk edge):
- FIFO count=0, pointers=0, out_valid=0.
- All field outputs, mem_read, mem_write and stall_cnt = 0.

Push and pop:
- Push = in_valid && in_ready.
- The decoded record (fields plus flags, and plus illegal if enabled) is written to the FIFO at the tail on that edge.
- Pop = out_valid && out_ready; the head advances on that edge.

in_ready:
- in_ready = (count < DEPTH) && rst_n.
- Registered-count based; no combinational dependence on out_ready.
- When full, a same-cycle pop does not enable a push.

Outputs:
- out_valid = (count != 0).
- Field outputs are driven from the FIFO head storage. While out_valid=0 they hold the last head value and are don't-care.
- Latency: an instruction accepted at edge N is visible with out_valid=1 after edge N (1 cycle) if the FIFO was empty.
- Order is strictly FIFO.

Simultaneous push and pop when 0<count<DEPTH:
- count is unchanged; both pointers advance.

Pointer wrap-around:
- Pointers are log2(DEPTH) bits and wrap naturally.
- count is log2(DEPTH)+1 bits.

Flush:
- Synchronous. On an edge with flush=1: count=0, pointers=0, out_valid=0 next cycle.
- A same-cycle push is dropped.
- A same-cycle pop has no external effect.
- in_ready is unaffected by flush.
- stall_cnt is not cleared.

stall_cnt:
- Increments on each edge where in_valid && !in_ready.
- Saturates at all-ones.
- Cleared only by reset.

Reset mid-operation:
- Everything returns to reset values.
- Buffered instructions are lost.

Optional Feature:
Macro: DECODE_ILLEGAL_EN

Defined:
- Adds parameter ALU_FUNC_MAX (default 4'd9).
- Adds output illegal (1 bit), stored per record: 1 when opcode==0 and func>ALU_FUNC_MAX.
- Illegal records still pass through the FIFO normally.
- Adds output illegal_cnt (CNT_W), which counts popped records with illegal=1 and saturates.
- illegal and illegal_cnt reset to 0.

Undefined:
- Neither port nor the associated logic exists.

Test Plan:

1. Reset, then push 32'h04C281E5 with out_ready=1.
   - Required: one cycle later out_valid=1 with opcode=0, rs=2, rt=12, shamt=5, func=0, offset=16'h81E5, mem_read=0, mem_write=0.

2. Push 32'h24C281E5, 44C281E5, 64C281E5, 84C281E5 back-to-back with out_ready=1.
   - Required: in-order output with opcode/rs pairs 0/18, 1/2, 1/18, 2/2.
   - mem_read=1 only on the last.
   - in_ready stays 1 throughout.

3. out_ready=0, push 3 instructions continuously.
   - Required: 2 accepted (DEPTH=2), in_ready=0 afterward, stall_cnt increments each blocked cycle.
   - Raising out_ready drains them in order.

4. Fill the FIFO with 2 entries, then assert flush together with in_valid.
   - Required: next cycle out_valid=0, count=0; the flushed-cycle instruction never appears at the output.

5. Assert rst_n=0 for one cycle while the FIFO is full and stall_cnt=5.
   - Required: out_valid=0, stall_cnt=0, in_ready=1 after reset is released.

6. DECODE_ILLEGAL_EN only: push 32'h0004F000 (opcode 0, func 4'hE).
   - Required: output illegal=1; illegal_cnt=1 after pop.
   - 32'h04C281E5 gives illegal=0.
